// File: rtl/line_burst_pkg.sv
// Shared types and helpers for the line burst sequencer.
package line_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    function automatic int ofs_bits(input int beats);
        return $clog2(beats);
    endfunction

endpackage

// File: rtl/line_burst_wdog.sv
// Per-beat watchdog: counts stalled cycles, flags expiry at TMO.
module burst_wdog #(
    parameter int TMO = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TMO + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires in the TMO-th stalled cycle so the strobe is held exactly TMO cycles.
    assign expire = enable && (cnt == CW'(TMO - 1));

endmodule

// File: rtl/line_burst_ctrl.sv
// Line burst sequencer between the cache miss port and main memory.
module line_burst_ctrl
    import line_burst_pkg::*;
#(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 8,
    parameter int BEATS  = 4,
    parameter int TMO    = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [AWIDTH-1:0]        req_addr,
    input  logic [DWIDTH*BEATS-1:0]  wb_line,
    output logic [DWIDTH*BEATS-1:0]  fill_line,
    output logic                     done,
    output logic                     err,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [AWIDTH-1:0]        mem_addr,
    output logic [DWIDTH-1:0]        mem_wdata,
    input  logic [DWIDTH-1:0]        mem_rdata,
    input  logic                     mem_ready
);

    localparam int OFS = ofs_bits(BEATS);

    state_t                    state;
    state_t                    state_n;
    logic [AWIDTH-OFS-1:0]     line_q;
    logic [OFS-1:0]            beat;
    logic                      wr_q;
    logic                      err_q;
    logic [DWIDTH*BEATS-1:0]   wb_q;
    logic                      accept;
    logic                      beat_done;
    logic                      last_beat;
    logic                      expire;
    logic                      in_burst;

    assign in_burst  = (state == BURST);
    assign accept    = req_valid && req_ready;
    assign beat_done = in_burst && mem_ready;
    assign last_beat = beat_done && (beat == OFS'(BEATS - 1));

    burst_wdog #(
        .TMO     (TMO)
    ) u_wdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!in_burst || beat_done),
        .enable  (in_burst && !mem_ready),
        .expire  (expire)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) state_n = BURST;
            end
            BURST: begin
                mem_rd = !wr_q;
                mem_wr = wr_q;
                if (last_beat || expire) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_addr  = {line_q, beat};
    assign mem_wdata = wb_q[int'(beat)*DWIDTH +: DWIDTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_q    <= '0;
            beat      <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wb_q      <= '0;
            fill_line <= '0;
        end else begin
            if (accept) begin
                line_q <= req_addr[AWIDTH-1:OFS];
                beat   <= '0;
                wr_q   <= req_write;
                err_q  <= 1'b0;
                wb_q   <= wb_line;
            end
            if (beat_done) begin
                // Offset wraps within OFS bits; line bits never see a carry.
                beat <= beat + 1'b1;
                if (!wr_q) begin
                    fill_line[int'(beat)*DWIDTH +: DWIDTH] <= mem_rdata;
                end
            end
            if (expire) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_line_burst_ctrl.sv
// Scoreboard bench for line_burst_ctrl with a cycle-level memory responder.
module tb_line_burst_ctrl;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int BT = 4;
    localparam int TM = 16;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_write = 1'b0;
    logic [AW-1:0]  req_addr = '0;
    logic [31:0]    wb_line = '0;
    logic [31:0]    fill_line;
    logic           done;
    logic           err;
    logic           mem_rd;
    logic           mem_wr;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata = '0;
    logic           mem_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] fill_m = '0;
    logic [AW+DW-1:0] sbq[$];

    always #5 clock = ~clock;

    line_burst_ctrl #(
        .AWIDTH    (AW),
        .DWIDTH    (DW),
        .BEATS     (BT),
        .TMO       (TM)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .wb_line   (wb_line),
        .fill_line (fill_line),
        .done      (done),
        .err       (err),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // mode 0: ready every cycle, 1: ready every 2nd cycle, 2: never ready
    task automatic do_req(input bit wr, input logic [AW-1:0] addr,
                          input logic [31:0] wb, input int mode,
                          input logic [DW-1:0] base, input int exp_lat,
                          input bit exp_err, input bit keep,
                          input logic [AW-1:0] next_addr);
        int  cyc;
        int  rd_cnt;
        bit  got_done;
        bit  rdy;
        logic [AW+DW-1:0] e;
        logic [1:0] b;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        wb_line   = wb;
        chk("req_ready_idle", req_ready, 1);
        for (int i = 0; i < BT; i++) begin
            b = 2'(i);
            sbq.push_back({addr[AW-1:2], b, wb[i*DW +: DW]});
        end
        step();
        if (keep) begin
            req_addr = next_addr;
        end else begin
            req_valid = 1'b0;
            req_addr  = ~addr;
        end
        wb_line  = ~wb;
        cyc      = 1;
        rd_cnt   = 0;
        got_done = 1'b0;
        while (!got_done && cyc <= 40) begin
            if (done) begin
                got_done  = 1'b1;
                mem_ready = 1'b0;
                chk("done_latency", cyc, exp_lat);
                chk("err", err, exp_err);
                chk("fill_line", fill_line, fill_m);
                chk("strobes_done", {mem_rd, mem_wr}, 0);
                chk("req_ready_done", req_ready, 0);
                if (exp_err) chk("stall_cycles", rd_cnt, TM);
            end else begin
                chk("strobe", {mem_rd, mem_wr}, wr ? 2'b01 : 2'b10);
                rd_cnt++;
                rdy = (mode == 0) ? 1'b1 :
                      (mode == 1) ? (cyc % 2 == 0) : 1'b0;
                mem_ready = rdy;
                mem_rdata = base + DW'(mem_addr[1:0]);
                if (rdy) begin
                    if (sbq.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("mem_addr", mem_addr, e[AW+DW-1:DW]);
                        if (wr) chk("mem_wdata", mem_wdata, e[DW-1:0]);
                        else fill_m[int'(mem_addr[1:0])*DW +: DW] = mem_rdata;
                    end
                end else if (exp_err) begin
                    chk("stall_addr", mem_addr, {addr[AW-1:2], 2'b00});
                end
            end
            step();
            cyc++;
        end
        if (!got_done) chk("done_seen", 0, 1);
        if (!exp_err) chk("sb_drained", sbq.size(), 0);
        sbq.delete();
        chk("done_pulse", done, 0);
        chk("req_ready_after", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_strobes", {mem_rd, mem_wr}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_fill", fill_line, 0);
        reset_n = 1'b1;
        step();

        do_req(1'b0, 9'h015, 32'h0, 0, 8'hA0, 5, 1'b0, 1'b0, 9'h0);
        chk("fill_const", fill_line, 32'hA3A2A1A0);

        do_req(1'b1, 9'h100, 32'hDEADBEEF, 1, 8'h00, 9, 1'b0, 1'b0, 9'h0);
        chk("fill_after_wb", fill_line, 32'hA3A2A1A0);

        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            #1;
            chk("idle_strobes", {mem_rd, mem_wr}, 0);
            chk("idle_ready", req_ready, 1);
            step();
        end
        mem_ready = 1'b0;

        do_req(1'b0, 9'h0C6, 32'h0, 2, 8'h00, TM + 1, 1'b1, 1'b0, 9'h0);

        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 9'h041;
        step();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 8'h55;
        step();
        step();
        chk("pre_rst_addr", mem_addr, 9'h042);
        chk("pre_rst_rd", mem_rd, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {mem_rd, mem_wr}, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_fill", fill_line, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ready", req_ready, 1);
        fill_m = '0;
        mem_ready = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_nodone", done, 0);
        end

        do_req(1'b0, 9'h083, 32'h0, 0, 8'h30, 5, 1'b0, 1'b1, 9'h1F2);
        do_req(1'b1, 9'h1F2, 32'h12345678, 0, 8'h00, 5, 1'b0, 1'b0, 9'h0);
        chk("fill_kept", fill_line, 32'h33323130);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
